// File: rtl/coax_rx_ctrl.sv
// coax_rx sequencing controller: frames received words, tags last/error, and
// buffers them in a first-word-fall-through FIFO for the host.
module coax_rx_ctrl #(
   parameter int DEPTH   = 8,
   parameter int HOLDOFF = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        rx_active,
   input  logic        rx_strobe,
   input  logic        rx_error,
   input  logic [9:0]  rx_data,
   output logic        rx_reset,
   input  logic        rd_strobe,
   output logic [11:0] rd_data,
   output logic        empty,
   output logic        full,
   output logic        overflow,
   output logic [7:0]  frame_count,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      ST_DISABLED,
      ST_IDLE,
      ST_RECEIVE,
      ST_ERROR,
      ST_HOLDOFF
   } state_t;

   state_t        state;
   logic [9:0]    hold_data;
   logic          hold_valid;
   logic [9:0]    err_code;
   logic [HW-1:0] hold_cnt;

   logic          push_en;
   logic [11:0]   push_data;
   logic          do_push;
   logic          do_pop;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [11:0]   mem [DEPTH];

   // Push decode: the held word is committed once the next event reveals
   // whether it was the final word of the frame.
   always_comb begin
      push_en   = 1'b0;
      push_data = '0;
      if (enable) begin
         case (state)
            ST_RECEIVE: begin
               if (rx_error || rx_strobe) begin
                  push_en   = hold_valid;
                  push_data = {2'b00, hold_data};
               end else if (!rx_active) begin
                  push_en   = hold_valid;
                  push_data = {2'b10, hold_data};
               end
            end
            ST_ERROR: begin
               push_en   = 1'b1;
               push_data = {2'b11, err_code};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_DISABLED;
         rx_reset    <= 1'b1;
         busy        <= 1'b0;
         hold_data   <= '0;
         hold_valid  <= 1'b0;
         err_code    <= '0;
         hold_cnt    <= '0;
         frame_count <= '0;
      end else if (!enable) begin
         state      <= ST_DISABLED;
         rx_reset   <= 1'b1;
         busy       <= 1'b0;
         hold_valid <= 1'b0;
      end else begin
         case (state)
            ST_DISABLED: begin
               state      <= ST_IDLE;
               rx_reset   <= 1'b0;
               busy       <= 1'b0;
               hold_valid <= 1'b0;
            end
            ST_IDLE: begin
               if (rx_error) begin
                  err_code <= rx_data;
                  state    <= ST_ERROR;
                  rx_reset <= 1'b1;
                  busy     <= 1'b1;
               end else if (rx_active) begin
                  state <= ST_RECEIVE;
                  busy  <= 1'b1;
               end
            end
            ST_RECEIVE: begin
               if (rx_error) begin
                  err_code   <= rx_data;
                  hold_valid <= 1'b0;
                  state      <= ST_ERROR;
                  rx_reset   <= 1'b1;
               end else if (rx_strobe) begin
                  hold_data  <= rx_data;
                  hold_valid <= 1'b1;
               end else if (!rx_active) begin
                  hold_valid <= 1'b0;
                  if (hold_valid) frame_count <= frame_count + 8'd1;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_ERROR: begin
               frame_count <= frame_count + 8'd1;
               rx_reset    <= 1'b0;
               hold_valid  <= 1'b0;
               hold_cnt    <= HW'(HOLDOFF - 1);
               state       <= ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else if (!rx_active) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= ST_DISABLED;
               rx_reset <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = rd_strobe && !empty;
   assign do_push = push_en && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (!enable) overflow <= 1'b0;
         else if (push_en && !do_push) overflow <= 1'b1;
      end
   end

endmodule
